// File: rtl/sgd_rd_pkg.sv
// Shared constants, tags and FSM state type for the SGD HBM read master.
package sgd_rd_pkg;

  localparam logic [7:0] MEM_RD_A_TAG = 8'h0A;
  localparam logic [7:0] MEM_RD_B_TAG = 8'h0B;

  localparam int HBM_LINE_BYTES = 64;
  localparam int AXI_4K         = 4096;
  localparam int LINE_SHIFT     = 6;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } rd_state_t;

endpackage

// File: rtl/sgd_rd_burst_split.sv
// Combinational burst sizing: min(remaining, MAX_BURST, lines left in the 4 KiB page),
// plus the address and remaining count after that burst.
module sgd_rd_burst_split
  import sgd_rd_pkg::*;
#(
  parameter int ADDR_W    = 34,
  parameter int MAX_BURST = 16
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       remaining_i,
  output logic [8:0]        len_o,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [31:0]       next_remaining_o
);

  localparam logic [6:0] LINES_PER_4K = 7'(AXI_4K / HBM_LINE_BYTES);

  logic [31:0] lines_to_4k;
  logic [31:0] len32;

  assign lines_to_4k = 32'(LINES_PER_4K - {1'b0, addr_i[11:6]});

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    len32 = remaining_i;
    if (len32 > 32'(MAX_BURST)) len32 = 32'(MAX_BURST);
    if (len32 > lines_to_4k)    len32 = lines_to_4k;
  end

  assign len_o            = len32[8:0];
  assign next_addr_o      = addr_i + (ADDR_W'(len32) << LINE_SHIFT);
  assign next_remaining_o = remaining_i - len32;

endmodule

// File: rtl/sgd_hbm_rd_master.sv
// AXI4 read initiator: splits line-granular commands into 4K-safe bursts, caps outstanding
// reads and streams tagged beats to the engine. Optional counters: SGD_RD_PERF_CNT_EN.
module sgd_hbm_rd_master
  import sgd_rd_pkg::*;
#(
  parameter int ADDR_W    = 34,
  parameter int DATA_W    = 512,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUTS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_beats,
  input  logic [7:0]        cmd_tag,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [5:0]        m_arid,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_tag,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       perf_beats,
  output logic [31:0]       perf_stalls
);

  localparam int OUTS_W = $clog2(MAX_OUTS + 1);
  localparam int PTR_W  = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

  rd_state_t         state_q;
  logic [ADDR_W-1:0] addr_q, araddr_q;
  logic [31:0]       rem_q, out_rem_q;
  logic [7:0]        tag_q, arlen_q;
  logic              arvalid_q, cmd_ready_q, done_q, err_q;
  logic              out_valid_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [7:0]        out_tag_q;
  logic [OUTS_W-1:0] outs_q, outs_d;
  logic [8:0]        len_fifo_q [MAX_OUTS];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [8:0]        r_cnt_q;

  logic              cmd_hs, ar_hs, r_hs, out_hs, rlast_hs, slot_free, rlast_bad;
  logic [ADDR_W-1:0] split_addr, split_next_addr;
  logic [31:0]       split_rem, split_next_rem;
  logic [8:0]        split_len;

  assign cmd_hs   = cmd_valid & cmd_ready_q;
  assign ar_hs    = arvalid_q & m_arready;
  assign r_hs     = m_rvalid & m_rready;
  assign out_hs   = out_valid_q & out_ready;
  assign rlast_hs = r_hs & m_rlast & (outs_q != '0);
  assign m_rready = ~rst & (~out_valid_q | out_ready);

  // While idle the splitter sizes the first burst straight from the command port.
  assign split_addr = ((state_q == ST_IDLE) ? cmd_addr : addr_q) & ~ADDR_W'(HBM_LINE_BYTES - 1);
  assign split_rem  = (state_q == ST_IDLE) ? cmd_beats : rem_q;

  sgd_rd_burst_split #(
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) u_split (
    .addr_i           (split_addr),
    .remaining_i      (split_rem),
    .len_o            (split_len),
    .next_addr_o      (split_next_addr),
    .next_remaining_o (split_next_rem)
  );

  always_comb begin
    outs_d = outs_q;
    if (ar_hs && !rlast_hs)      outs_d = outs_q + 1'b1;
    else if (!ar_hs && rlast_hs) outs_d = outs_q - 1'b1;
  end

  assign slot_free = (~arvalid_q | m_arready) & (outs_d < OUTS_W'(MAX_OUTS));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (ar_hs) arvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_hs) begin
            tag_q <= cmd_tag;
            if (cmd_beats == 32'd0) begin
              done_q <= 1'b1;
            end else begin
              cmd_ready_q <= 1'b0;
              state_q     <= ST_ISSUE;
              araddr_q    <= split_addr;
              arlen_q     <= 8'(split_len - 9'd1);
              arvalid_q   <= 1'b1;
              addr_q      <= split_next_addr;
              rem_q       <= split_next_rem;
            end
          end
        end
        ST_ISSUE: begin
          if (rem_q != 32'd0 && slot_free) begin
            araddr_q  <= split_addr;
            arlen_q   <= 8'(split_len - 9'd1);
            arvalid_q <= 1'b1;
            addr_q    <= split_next_addr;
            rem_q     <= split_next_rem;
          end else if (ar_hs && rem_q == 32'd0) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_hs && out_last_q) begin
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the burst-length FIFO storage has no reset; the pointers and outs_q define validity.
  always_ff @(posedge clk) begin
    if (ar_hs) len_fifo_q[wr_ptr_q] <= {1'b0, arlen_q} + 9'd1;
  end

  assign rlast_bad = m_rlast & ((outs_q == '0) | (r_cnt_q + 9'd1 != len_fifo_q[rd_ptr_q]));

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      r_cnt_q     <= '0;
      out_rem_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      outs_q <= outs_d;
      if (ar_hs) wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTS - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (cmd_hs) out_rem_q <= cmd_beats;
      else if (r_hs && out_rem_q != 32'd0) out_rem_q <= out_rem_q - 32'd1;
      if (r_hs) begin
        out_valid_q <= 1'b1;
        out_data_q  <= m_rdata;
        out_tag_q   <= tag_q;
        out_last_q  <= (out_rem_q == 32'd1);
        r_cnt_q     <= m_rlast ? 9'd0 : r_cnt_q + 9'd1;
        if (m_rresp != 2'b00 || rlast_bad) err_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (rlast_hs) rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTS - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

`ifdef SGD_RD_PERF_CNT_EN
  logic [31:0] perf_beats_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_beats_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (out_hs) perf_beats_q <= perf_beats_q + 32'd1;
      if ((arvalid_q & ~m_arready) | (out_valid_q & ~out_ready))
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_beats  = perf_beats_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_beats  = '0;
  assign perf_stalls = '0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = AXI_SIZE_64B;
  assign m_arburst = AXI_BURST_INCR;
  assign m_arid    = '0;
  assign m_arvalid = arvalid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/sgd_hbm_rd_master.md
# sgd_hbm_rd_master

AXI4 read initiator that fetches SGD sample rows (A) and labels (B) from one HBM pseudo-channel and streams them into the SGD engine. One instance sits per engine between the engine's command logic and its `axi_mm` HBM port. Each accepted command covers a contiguous region of 64-byte lines. The block splits it into legal bursts, limits outstanding reads, and returns each data beat tagged with the command's tag.

## Interface
Parameters:
- ADDR_W, 34: byte address width of `araddr`.
- DATA_W, 512: data beat width; one beat is one 64-byte line.
- MAX_BURST, 16: maximum beats per AR burst (1..256).
- MAX_OUTS, 8: maximum outstanding AR bursts.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_addr  in  ADDR_W  start byte address; bits [5:0] ignored and treated as 0.
- cmd_beats  in  32  number of lines to read.
- cmd_tag  in  8  `MEM_RD_A_TAG` or `MEM_RD_B_TAG`, echoed on every output beat.
- m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_arvalid / m_arready  out (arready in)  ADDR_W, 8, 3, 2, 6, 1 / 1  AR channel of `axi_mm`.
- m_rdata, m_rresp, m_rlast, m_rvalid / m_rready  in (rready out)  DATA_W, 2, 1, 1 / 1  R channel.
- out_data, out_tag, out_last, out_valid / out_ready  out (ready in)  DATA_W, 8, 1, 1 / 1  data stream to the engine.
- done  out  1  one-cycle pulse when the final beat of a command leaves on `out`.
- err  out  1  sticky flag; cleared only by `rst`.
- perf_beats, perf_stalls  out  32, 32  performance counters (see Configuration).

## Operation
- State machine: IDLE → ISSUE → DRAIN → IDLE.
  - IDLE: `cmd_ready`=1. On handshake, latch addr/beats/tag. If beats=0, pulse `done` next cycle and stay in IDLE. Otherwise go to ISSUE.
  - ISSUE: drive AR. After the handshake of the final burst, go to DRAIN.
  - DRAIN: wait until `out` has emitted every beat, then pulse `done` and go to IDLE.
- Burst length: `len = min(remaining, MAX_BURST, (4096 − addr[11:0])/64)`.
  - `m_arlen` = len−1; `m_arsize`=3'b110; `m_arburst`=INCR; `m_arid`=0.
  - On AR handshake: `addr += len*64`, `remaining -= len`.
- Outstanding count `outs`:
  - +1 on AR handshake; −1 on an R handshake with `m_rlast`; unchanged if both happen in the same cycle.
  - `m_arvalid` is held low while `outs==MAX_OUTS`.
- R path: one registered output stage. `m_rready = ~out_valid | out_ready`. `out_data`/`out_tag` are loaded on an R handshake.
- `out_last`=1 on the final beat of the command. It does not mirror `m_rlast`.
- Any `m_rresp != 0` sets `err`. Data is still forwarded unchanged.
- `m_rlast` arriving on a beat that does not match the per-burst beat count also sets `err`.

## Timing
- Reset values: `cmd_ready`=0, all valids=0, `done`=0, `err`=0, `outs`=0, counters=0, state=IDLE, data/addr outputs=0.
- `cmd_ready` goes high in the first cycle after `rst` deasserts.
- AR: first `m_arvalid` rises one cycle after the cmd handshake. Back-to-back bursts are issued every cycle while `m_arready`=1 and `outs<MAX_OUTS`.
- AR stability: `m_araddr`/`m_arlen` stay stable while `m_arvalid`=1 and `m_arready`=0.
- R→out latency is 1 cycle; full throughput when `out_ready` is held high.
- Backpressure: if `out_valid`=1 and `out_ready`=0, then `m_rready`=0 and `out_data` is held.
- `done` is asserted in the cycle after the `out_last` handshake. A new command may be accepted in the following cycle.
- Reset mid-operation: all state is dropped immediately and outstanding bursts are abandoned. `m_rready` stays 0 while `rst`=1.

## Configuration
- `SGD_RD_PERF_CNT_EN` defined:
  - `perf_beats` counts `out` handshakes.
  - `perf_stalls` counts cycles with `m_arvalid & ~m_arready` or `out_valid & ~out_ready`.
  - Both are 32-bit, wrap at 2^32, and are cleared by `rst`.
- Undefined: both ports are tied to 0 and no counter logic is synthesized.

## Structure
- Package `sgd_rd_pkg` holds:
  - `MEM_RD_A_TAG` and `MEM_RD_B_TAG`
  - `HBM_LINE_BYTES`=64 and `AXI_4K`=4096
  - the state enum `rd_state_t`
- Sub-module `sgd_rd_burst_split`: combinational computation of `len` from `(addr, remaining, MAX_BURST)`, and the next addr/remaining values.

## Test plan
- Command addr=0, beats=16, tag=A, slave always ready → one AR with araddr=0 and arlen=15; 16 `out` beats, `out_last` on beat 16; `done` 1 cycle later.
- addr=0xFC0, beats=4 → two bursts: araddr=0xFC0 arlen=0, then araddr=0x1000 arlen=2.
- beats=200, MAX_OUTS=8, slave withholds R data → exactly 8 AR handshakes, then `m_arvalid` stays low until the first `m_rlast`.
- `out_ready` toggled 50% random, beats=37, tag=B → all 37 beats in order with tag B, none dropped or duplicated.
- Slave returns rresp=2 on beat 3 → `err`=1 and sticky; all beats still delivered.
- `rst` pulsed during DRAIN of beats=64, then a new command beats=1 → clean single-beat transfer and one `done` pulse.
